// File: rtl/usb_token_rx.sv
// USB token packet receiver: SYNC hunt, PID decode, 16-bit token capture, CRC5 checker control.
// Define USB_TOKEN_SOF_EN to also decode SOF packets (adds sof_valid and frame_num).
module usb_token_rx #(
  parameter int SYNC_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        d_bit,
  input  logic        bit_valid,
  input  logic        eop,
  input  logic        crc_pass,
  output logic        crc_clear,
  output logic        crc_serial,
  output logic        crc_shift_en,
  output logic        token_valid,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic        pid_err,
  output logic        crc_err,
  output logic        frm_err
`ifdef USB_TOKEN_SOF_EN
  ,
  output logic        sof_valid,
  output logic [10:0] frame_num
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CHECK,
    S_WAIT_EOP,
    S_IGNORE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t              state_reg;
  logic [SYNC_LEN-2:0] hist_reg;
  logic [SYNC_LEN-1:0] hist_next;
  logic [SYNC_LEN-1:0] sync_pattern;
  logic [6:0]          pid_sr_reg;
  logic [7:0]          pid_byte_next;
  logic [10:0]         data_sr_reg;
  logic [3:0]          bit_cnt_reg;
  logic [7:0]          to_cnt_reg;
  logic                crc_ok_reg;
  logic [3:0]          pid_shadow_reg;
  logic                pid_chk_ok;
  logic                is_token_pid;
  logic                timeout_hit;
  logic                pass_now;
`ifdef USB_TOKEN_SOF_EN
  logic                is_sof_reg;
`endif

  // SYNC pattern: SYNC_LEN-1 zeros followed by a one (newest bit in the LSB)
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
      assign sync_pattern[gi] = (gi == 0);
    end
  endgenerate

  assign hist_next     = {hist_reg, d_bit};
  assign pid_byte_next = {d_bit, pid_sr_reg};
  assign pid_chk_ok    = (pid_byte_next[7:4] == ~pid_byte_next[3:0]);
  assign is_token_pid  = (pid_byte_next[3:0] == 4'b0001) ||
                         (pid_byte_next[3:0] == 4'b1001) ||
                         (pid_byte_next[3:0] == 4'b1101);
  assign timeout_hit   = (to_cnt_reg == TO_LAST);
  // An eop landing in CHECK is resolved with the live pass flag
  assign pass_now      = (state_reg == S_CHECK) ? crc_pass : crc_ok_reg;

  assign crc_clear    = (state_reg == S_IDLE) || (state_reg == S_PID);
  assign crc_shift_en = (state_reg == S_DATA) && bit_valid && !eop;
  assign crc_serial   = (state_reg == S_DATA) && d_bit;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg      <= S_IDLE;
      hist_reg       <= '0;
      pid_sr_reg     <= '0;
      data_sr_reg    <= '0;
      bit_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      crc_ok_reg     <= 1'b0;
      pid_shadow_reg <= '0;
      pid            <= '0;
      addr           <= '0;
      endp           <= '0;
      token_valid    <= 1'b0;
      pid_err        <= 1'b0;
      crc_err        <= 1'b0;
      frm_err        <= 1'b0;
`ifdef USB_TOKEN_SOF_EN
      is_sof_reg     <= 1'b0;
      sof_valid      <= 1'b0;
      frame_num      <= '0;
`endif
    end else begin
      token_valid <= 1'b0;
      pid_err     <= 1'b0;
      crc_err     <= 1'b0;
      frm_err     <= 1'b0;
`ifdef USB_TOKEN_SOF_EN
      sof_valid   <= 1'b0;
`endif
      to_cnt_reg  <= bit_valid ? 8'd0 : to_cnt_reg + 8'd1;

      case (state_reg)
        S_IDLE: begin
          to_cnt_reg <= '0;
          if (eop) begin
            hist_reg <= '0;
          end else if (bit_valid) begin
            if (hist_next == sync_pattern) begin
              hist_reg    <= '0;
              bit_cnt_reg <= '0;
              state_reg   <= S_PID;
            end else begin
              hist_reg <= hist_next[SYNC_LEN-2:0];
            end
          end
        end

        S_PID: begin
          if (eop) begin
            frm_err    <= 1'b1;
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
          end else if (bit_valid) begin
            pid_sr_reg  <= pid_byte_next[7:1];
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_reg <= '0;
              to_cnt_reg  <= '0;
              if (!pid_chk_ok) begin
                pid_err   <= 1'b1;
                state_reg <= S_IGNORE;
              end else if (is_token_pid) begin
                pid_shadow_reg <= pid_byte_next[3:0];
                data_sr_reg    <= '0;
                state_reg      <= S_DATA;
`ifdef USB_TOKEN_SOF_EN
                is_sof_reg     <= 1'b0;
              end else if (pid_byte_next[3:0] == 4'b0101) begin
                data_sr_reg    <= '0;
                is_sof_reg     <= 1'b1;
                state_reg      <= S_DATA;
`endif
              end else begin
                state_reg <= S_IGNORE;
              end
            end
          end else if (timeout_hit) begin
            frm_err    <= 1'b1;
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
          end
        end

        S_DATA: begin
          if (eop) begin
            frm_err    <= 1'b1;
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
          end else if (bit_valid) begin
            // Only addr/endp (or frame number) are kept; the CRC bits go to the checker alone
            if (bit_cnt_reg < 4'd11) begin
              data_sr_reg[bit_cnt_reg] <= d_bit;
            end
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd15) begin
              bit_cnt_reg <= '0;
              to_cnt_reg  <= '0;
              state_reg   <= S_CHECK;
            end
          end else if (timeout_hit) begin
            frm_err    <= 1'b1;
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
          end
        end

        S_CHECK, S_WAIT_EOP: begin
          if (state_reg == S_CHECK) begin
            to_cnt_reg <= '0;
          end
          if (eop) begin
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
            if (pass_now) begin
`ifdef USB_TOKEN_SOF_EN
              if (is_sof_reg) begin
                sof_valid <= 1'b1;
                frame_num <= data_sr_reg;
              end else
`endif
              begin
                token_valid <= 1'b1;
                pid         <= pid_shadow_reg;
                addr        <= data_sr_reg[6:0];
                endp        <= data_sr_reg[10:7];
              end
            end else begin
              crc_err <= 1'b1;
            end
          end else if (bit_valid) begin
            frm_err    <= 1'b1;
            to_cnt_reg <= '0;
            state_reg  <= S_IGNORE;
          end else if (state_reg == S_CHECK) begin
            crc_ok_reg <= crc_pass;
            state_reg  <= S_WAIT_EOP;
          end else if (timeout_hit) begin
            frm_err    <= 1'b1;
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
          end
        end

        S_IGNORE: begin
          if (eop || (!bit_valid && timeout_hit)) begin
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
          end
        end

        default: begin
          to_cnt_reg <= '0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
